regfile_mp: RTL and testbench

- Parametrised successor to the core's 2R/1W register block. Configurable data width, register count and read-port count.
- Two write ports: A is the pipeline WB stage; B is the long-latency writeback for load-miss and MUL/DIV results.
- Adds a per-register busy scoreboard for the hazard unit.
- Adds a post-reset clear sequencer, so no memory-init file is needed and the array can map to RAM.
- Sits between decode (reads, issue) and writeback (writes).

---
 rtl/regfile_mp_if.sv | 23 ++
 rtl/regfile_mp.sv | 83 ++++++++
 tb/tb_regfile_mp.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback side bus of the multi-port register file
interface regfile_mp_if #(parameter int XLEN = 32, AW = 5, NRD = 2);
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wa_en;
  logic [AW-1:0]       wa_addr;
  logic [XLEN-1:0]     wa_data;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                init_done;
  modport master (
    output rs_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_addr,
    input  rd_data, rd_busy, init_done
  );
  modport slave (
    input  rs_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data, iss_en, iss_addr,
    output rd_data, rd_busy, init_done
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: NRD-read / 2-write register file with write bypass, busy scoreboard
// and a post-reset clear sequencer so the array itself needs no reset.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_ptr, w_ptr_nxt;
  logic                r_init_done, w_init_done_nxt;
  logic [NREGS-1:0]    r_busy, w_busy_nxt;
  logic [XLEN-1:0]     r_mem [NREGS];
  logic                w_ready, w_wa, w_wb, w_wa_mem;
  logic [NRD*XLEN-1:0] w_rd_data;
  logic [NRD-1:0]      w_rd_busy;
  assign w_ready  = r_state == READY;
  assign w_wa     = w_ready && bus.wa_en && bus.wa_addr != '0;
  assign w_wb     = w_ready && bus.wb_en && bus.wb_addr != '0;
  // port B wins a same-address collision, so A is suppressed rather than ordered
  assign w_wa_mem = w_wa && !(w_wb && bus.wb_addr == bus.wa_addr);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= CLEAR;
      r_ptr       <= AW'(1);
      r_init_done <= 1'b0;
      r_busy      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_init_done <= w_init_done_nxt;
      r_busy      <= w_busy_nxt;
    end
  end
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_init_done_nxt = r_init_done;
    if (r_state == CLEAR) begin
      w_ptr_nxt = r_ptr + 1'b1;
      if (r_ptr == AW'(NREGS - 1)) begin
        w_state_nxt     = READY;
        w_init_done_nxt = 1'b1;
      end
    end
  end
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 1; r < NREGS; r++) begin
      if ((w_wa && bus.wa_addr == AW'(r)) || (w_wb && bus.wb_addr == AW'(r))) w_busy_nxt[r] = 1'b0;
      if (w_ready && bus.iss_en && bus.iss_addr == AW'(r)) w_busy_nxt[r] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) r_mem[r_ptr] <= '0;
    else begin
      if (w_wa_mem) r_mem[bus.wa_addr] <= bus.wa_data;
      if (w_wb) r_mem[bus.wb_addr] <= bus.wb_data;
    end
  end
  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit_a, w_hit_b;
    assign w_ra    = bus.rs_addr[g*AW +: AW];
    assign w_hit_a = w_wa && bus.wa_addr == w_ra;
    assign w_hit_b = w_wb && bus.wb_addr == w_ra;
    assign w_rd_data[g*XLEN +: XLEN] = (!w_ready || w_ra == '0) ? '0 :
                                       w_hit_b ? bus.wb_data :
                                       w_hit_a ? bus.wa_data : r_mem[w_ra];
    // a write landing now resolves the hazard unless a new producer issues too
    assign w_rd_busy[g] = w_ready && w_ra != '0 && r_busy[w_ra] &&
                          !((w_hit_a || w_hit_b) && !(bus.iss_en && bus.iss_addr == w_ra));
  end
  assign bus.rd_data   = w_rd_data;
  assign bus.rd_busy   = w_rd_busy;
  assign bus.init_done = r_init_done;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors for clear sequencing, bypass, write priority and scoreboard
module tb_regfile_mp;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2)) bus ();
  regfile_mp #(.XLEN(32), .NREGS(32), .AW(5), .NRD(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1);
    bus.rs_addr = {a1, a0};
  endtask
  task automatic clear_run(input string tag);
    for (int c = 0; c < 31; c++) begin
      if (c > 0) begin
        @(negedge clk);
        #1;
      end
      chk({tag, "_done"}, bus.init_done, 0);
      chk({tag, "_rd"}, bus.rd_data[31:0], 0);
      chk({tag, "_busy"}, bus.rd_busy, 0);
    end
    @(negedge clk);
    #1;
    chk({tag, "_done_rise"}, bus.init_done, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.rs_addr = '0; bus.wa_en = 0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_en = 0; bus.wb_addr = '0; bus.wb_data = '0; bus.iss_en = 0; bus.iss_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_done", bus.init_done, 0);
    set_rs(5, 5);
    reset = 1'b1;
    #1;
    clear_run("clr1");
    for (int r = 1; r < 32; r += 2) begin
      @(negedge clk);
      set_rs(5'(r), 5'(r == 31 ? 1 : r + 1));
      #1;
      chk("zero0", bus.rd_data[31:0], 0);
      chk("zero1", bus.rd_data[63:32], 0);
    end
    @(negedge clk);
    bus.wa_en = 1; bus.wa_addr = 3; bus.wa_data = 32'hDEADBEEF; set_rs(3, 0);
    #1;
    chk("wa_byp", bus.rd_data[31:0], 32'hDEADBEEF);
    @(negedge clk);
    bus.wa_en = 0;
    #1;
    chk("wa_arr", bus.rd_data[31:0], 32'hDEADBEEF);
    @(negedge clk);
    bus.wa_en = 1; bus.wa_addr = 7; bus.wa_data = 32'h11;
    bus.wb_en = 1; bus.wb_addr = 7; bus.wb_data = 32'h22; set_rs(7, 7);
    #1;
    chk("ab_byp1", bus.rd_data[63:32], 32'h22);
    chk("ab_byp0", bus.rd_data[31:0], 32'h22);
    @(negedge clk);
    bus.wa_en = 0; bus.wb_en = 0;
    #1;
    chk("ab_arr", bus.rd_data[63:32], 32'h22);
    @(negedge clk);
    bus.iss_en = 1; bus.iss_addr = 9; set_rs(9, 9);
    #1;
    chk("iss_same", bus.rd_busy[0], 0);
    @(negedge clk);
    bus.iss_en = 0;
    #1;
    chk("busy_set0", bus.rd_busy[0], 1);
    chk("busy_set1", bus.rd_busy[1], 1);
    @(negedge clk);
    bus.wb_en = 1; bus.wb_addr = 9; bus.wb_data = 32'h55;
    #1;
    chk("wb_busy_byp", bus.rd_busy[0], 0);
    chk("wb_data_byp", bus.rd_data[31:0], 32'h55);
    @(negedge clk);
    bus.wb_en = 0;
    #1;
    chk("wb_busy_clr", bus.rd_busy[0], 0);
    chk("wb_data_arr", bus.rd_data[31:0], 32'h55);
    @(negedge clk);
    bus.iss_en = 1; bus.iss_addr = 9; bus.wa_en = 1; bus.wa_addr = 9; bus.wa_data = 32'h66;
    #1;
    chk("isswr_busy", bus.rd_busy[0], 0);
    chk("isswr_data", bus.rd_data[31:0], 32'h66);
    @(negedge clk);
    bus.iss_en = 0; bus.wa_en = 0;
    #1;
    chk("isswr_set", bus.rd_busy[0], 1);
    chk("isswr_arr", bus.rd_data[31:0], 32'h66);
    @(negedge clk);
    bus.iss_en = 1; bus.iss_addr = 10; set_rs(9, 10);
    @(negedge clk);
    bus.iss_en = 0; bus.wa_en = 1; bus.wa_addr = 10; bus.wa_data = 32'h77;
    #1;
    chk("wa_busy_byp", bus.rd_busy[1], 0);
    chk("other_busy", bus.rd_busy[0], 1);
    @(negedge clk);
    bus.wa_en = 0;
    #1;
    chk("wa_busy_clr", bus.rd_busy[1], 0);
    @(negedge clk);
    bus.wa_en = 1; bus.wa_addr = 0; bus.wa_data = 32'hFFFF;
    bus.wb_en = 1; bus.wb_addr = 0; bus.wb_data = 32'hFFFF;
    bus.iss_en = 1; bus.iss_addr = 0; set_rs(0, 0);
    #1;
    chk("x0_rd0", bus.rd_data[31:0], 0);
    chk("x0_rd1", bus.rd_data[63:32], 0);
    chk("x0_busy", bus.rd_busy, 0);
    @(negedge clk);
    bus.wa_en = 0; bus.wb_en = 0; bus.iss_en = 0;
    #1;
    chk("x0_arr", bus.rd_data, 0);
    chk("x0_busy_nx", bus.rd_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("async_rst", bus.init_done, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    bus.wa_en = 1; bus.wa_addr = 2; bus.wa_data = 32'hAB; set_rs(2, 3);
    #1;
    chk("mid_rst", bus.init_done, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    clear_run("clr2");
    bus.wa_en = 0;
    #1;
    chk("clr_wr_ign", bus.rd_data[31:0], 0);
    chk("clr_x3", bus.rd_data[63:32], 0);
    @(negedge clk);
    set_rs(9, 9);
    #1;
    chk("busy_rst", bus.rd_busy, 0);
    chk("x9_clr", bus.rd_data[31:0], 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
